// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_decoder_pkg                                                |
// | Segment codes, BCD markers and FSM encoding for the scan decoder.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg7_scan_decoder_pkg;

    // Segment codes are g..a, active-high
    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h67;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    localparam logic [3:0] c_BCD_BLANK = 4'hF;
    localparam logic [3:0] c_BCD_BAD   = 4'hE;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TRACK = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_to_bcd                                                          |
// | Combinational 7-segment pattern to BCD lookup with bad-pattern flag. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_to_bcd
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       bad
);

    always_comb begin
        bcd = c_BCD_BAD;
        bad = 1'b0;
        case (seg)
            c_SEG_0:     bcd = 4'd0;
            c_SEG_1:     bcd = 4'd1;
            c_SEG_2:     bcd = 4'd2;
            c_SEG_3:     bcd = 4'd3;
            c_SEG_4:     bcd = 4'd4;
            c_SEG_5:     bcd = 4'd5;
            c_SEG_6:     bcd = 4'd6;
            c_SEG_7:     bcd = 4'd7;
            c_SEG_8:     bcd = 4'd8;
            c_SEG_9:     bcd = 4'd9;
            c_SEG_BLANK: bcd = c_BCD_BLANK;
            default:     bad = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_decoder                                                    |
// | Recovers per-digit BCD values from a multiplexed 7-segment bus.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     dig_valid,
    output logic                  frame_done,
    output logic                  bad_pat,
    output logic                  bad_sel
);

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYC);

    logic [6:0]          r_seg_q;
    logic [DIGITS-1:0]   r_dig_q;
    logic [1:0]          r_state;
    logic [6:0]          r_lat_seg;
    logic [DIGITS-1:0]   r_lat_dig;
    logic [7:0]          r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_dig_valid;
    logic [DIGITS-1:0]   r_mask;
    logic                r_frame_done;
    logic                r_bad_pat;
    logic                r_bad_sel;
    logic                r_sel_err_q;

    logic                w_onehot;
    logic                w_sel_err;
    logic                w_same;
    logic [1:0]          w_state_nxt;
    logic [6:0]          w_lat_seg_nxt;
    logic [DIGITS-1:0]   w_lat_dig_nxt;
    logic [7:0]          w_cnt_nxt;
    logic                w_accept;
    logic [DIGITS-1:0]   w_mask_set;
    logic [3:0]          w_dec_bcd;
    logic                w_dec_bad;

    assign w_onehot   = (r_dig_q != '0) && ((r_dig_q & (r_dig_q - DIGITS'(1))) == '0);
    assign w_sel_err  = (r_dig_q != '0) && !w_onehot;
    assign w_same     = (r_seg_q == r_lat_seg) && (r_dig_q == r_lat_dig);
    assign w_mask_set = w_accept ? r_lat_dig : '0;

    // Decoding the latched pattern is safe: on the accept cycle it equals the sample
    seg7_to_bcd u_dec (
        .seg (r_lat_seg),
        .bcd (w_dec_bcd),
        .bad (w_dec_bad)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_seg_nxt = r_lat_seg;
        w_lat_dig_nxt = r_lat_dig;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        case (r_state)
            c_ST_TRACK: begin
                if (w_same) begin
                    if (r_cnt >= c_STABLE - 8'd1) begin
                        w_cnt_nxt   = c_STABLE;
                        w_accept    = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else if (w_onehot) begin
                    w_lat_seg_nxt = r_seg_q;
                    w_lat_dig_nxt = r_dig_q;
                    w_cnt_nxt     = 8'd1;
                end else begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_HOLD: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_lat_seg_nxt = r_seg_q;
                        w_lat_dig_nxt = r_dig_q;
                        w_cnt_nxt     = 8'd1;
                        w_state_nxt   = c_ST_TRACK;
                    end else begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                if (w_onehot) begin
                    w_lat_seg_nxt = r_seg_q;
                    w_lat_dig_nxt = r_dig_q;
                    w_cnt_nxt     = 8'd1;
                    w_state_nxt   = c_ST_TRACK;
                end else begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q   <= '0;
            r_dig_q   <= '0;
            r_state   <= c_ST_IDLE;
            r_lat_seg <= '0;
            r_lat_dig <= '0;
            r_cnt     <= 8'd0;
        end else begin
            r_seg_q   <= seg;
            r_dig_q   <= dig;
            r_state   <= w_state_nxt;
            r_lat_seg <= w_lat_seg_nxt;
            r_lat_dig <= w_lat_dig_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd        <= {DIGITS{c_BCD_BLANK}};
            r_dig_valid  <= '0;
            r_mask       <= '0;
            r_frame_done <= 1'b0;
            r_bad_pat    <= 1'b0;
            r_bad_sel    <= 1'b0;
            r_sel_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_accept && r_lat_dig[i]) begin
                    r_bcd[4*i +: 4] <= w_dec_bcd;
                    r_dig_valid[i]  <= 1'b1;
                end
            end
            // A full mask is reported one cycle after it fills, then restarts
            if (&r_mask) begin
                r_frame_done <= 1'b1;
                r_mask       <= w_mask_set;
            end else begin
                r_frame_done <= 1'b0;
                r_mask       <= r_mask | w_mask_set;
            end
            r_bad_pat   <= w_accept && w_dec_bad;
            r_bad_sel   <= w_sel_err && !r_sel_err_q;
            r_sel_err_q <= w_sel_err;
        end
    end

    assign bcd        = r_bcd;
    assign dig_valid  = r_dig_valid;
    assign frame_done = r_frame_done;
    assign bad_pat    = r_bad_pat;
    assign bad_sel    = r_bad_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_decoder                                                 |
// | Directed stimulus with an event scoreboard for seg7_scan_decoder.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 4;

    // Event kinds seen by the monitor
    localparam int c_EV_UPD   = 0;
    localparam int c_EV_FRAME = 1;
    localparam int c_EV_BADP  = 2;
    localparam int c_EV_BADS  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h00;
    logic [3:0]  dig = 4'h0;
    logic [15:0] bcd;
    logic [3:0]  dig_valid;
    logic        frame_done;
    logic        bad_pat;
    logic        bad_sel;

    seg7_scan_decoder #(
        .DIGITS     (DIGITS),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig        (dig),
        .bcd        (bcd),
        .dig_valid  (dig_valid),
        .frame_done (frame_done),
        .bad_pat    (bad_pat),
        .bad_sel    (bad_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          cyc;
        logic [19:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    bit          rst_at_edge = 1'b1;
    logic [15:0] m_bcd = 16'hFFFF;
    logic [3:0]  m_valid = 4'h0;
    logic [3:0]  m_mask = 4'h0;
    logic [15:0] prev_bcd = 16'hFFFF;
    logic [3:0]  prev_valid = 4'h0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic push(input int kind, input int c, input logic [19:0] v);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic compare_event(input int kind, input logic [19:0] val);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%h, required none", kind, cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.val === val)
                passes++;
            else
                $display("FAIL event: got kind=%0d cyc=%0d val=%h, required kind=%0d cyc=%0d val=%h",
                         kind, cyc, val, e.kind, e.cyc, e.val);
        end
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: any visible output activity must match the next queued expectation
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            if (bcd !== prev_bcd || dig_valid !== prev_valid)
                compare_event(c_EV_UPD, {dig_valid, bcd});
            if (frame_done !== 1'b0) compare_event(c_EV_FRAME, 20'h0);
            if (bad_pat !== 1'b0)    compare_event(c_EV_BADP, 20'h0);
            if (bad_sel !== 1'b0)    compare_event(c_EV_BADS, 20'h0);
        end
        prev_bcd   = bcd;
        prev_valid = dig_valid;
    end

    // Drive one digit for 'hold' cycles; nib/bad are the hand-decoded results
    task automatic present(input int d, input logic [6:0] s, input int hold,
                           input logic [3:0] nib, input bit bad);
        int          t0;
        logic [15:0] nb;
        logic [3:0]  nv;
        seg = s;
        dig = 4'(1 << d);
        t0  = cyc;
        if (hold >= STABLE_CYC) begin
            nb = m_bcd;
            nb[4*d +: 4] = nib;
            nv = m_valid | dig;
            if (nb !== m_bcd || nv !== m_valid)
                push(c_EV_UPD, t0 + STABLE_CYC + 1, {nv, nb});
            m_bcd   = nb;
            m_valid = nv;
            if (bad) push(c_EV_BADP, t0 + STABLE_CYC + 1, 20'h0);
            m_mask = m_mask | dig;
            if (m_mask == 4'hF) begin
                push(c_EV_FRAME, t0 + STABLE_CYC + 2, 20'h0);
                m_mask = 4'h0;
            end
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic idle(input int n);
        seg = 7'h00;
        dig = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_bcd", {4'h0, bcd}, 20'h0FFFF);
        check("reset_valid", {16'h0, dig_valid}, 20'h0);
        check("reset_frame", {19'h0, frame_done}, 20'h0);
        check("reset_bad_pat", {19'h0, bad_pat}, 20'h0);
        check("reset_bad_sel", {19'h0, bad_sel}, 20'h0);
        idle(20);
        check("idle_bcd", {dig_valid, bcd}, 20'h0FFFF);

        present(0, 7'h5B, 6, 4'h2, 1'b0);
        present(0, 7'h4F, 3, 4'h3, 1'b0);
        idle(8);

        for (int p = 0; p < 2; p++) begin
            present(0, 7'h3F, 6, 4'h0, 1'b0);
            present(1, 7'h66, 6, 4'h4, 1'b0);
            present(2, 7'h7D, 6, 4'h6, 1'b0);
            present(3, 7'h67, 6, 4'h9, 1'b0);
        end
        idle(4);
        check("scan_bcd", {dig_valid, bcd}, 20'hF9640);

        present(1, 7'h49, 6, 4'hE, 1'b1);
        present(1, 7'h00, 6, 4'hF, 1'b0);
        idle(4);

        seg = 7'h3F;
        dig = 4'b0011;
        push(c_EV_BADS, cyc + 2, 20'h0);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            seg = k[0] ? 7'h06 : 7'h3F;
            dig = 4'b0001;
            repeat (2) @(negedge clk);
        end
        idle(4);
        check("after_bad_bcd", {dig_valid, bcd}, 20'hF96F0);

        seg = 7'h6D;
        dig = 4'b0100;
        t0  = cyc;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bcd", {4'h0, bcd}, 20'h0FFFF);
        check("midrst_valid", {16'h0, dig_valid}, 20'h0);
        m_bcd   = 16'hFFFF;
        m_valid = 4'h0;
        m_mask  = 4'h0;
        push(c_EV_UPD, t0 + 9, {4'b0100, 16'hF5FF});
        repeat (4) @(negedge clk);
        check("midrst_no_early_accept", {dig_valid, bcd}, 20'h0FFFF);
        repeat (4) @(negedge clk);
        idle(6);

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
